// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and its busy-bit scoreboard.
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  function automatic int calc_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int REG_ZERO = 0;

  typedef logic [calc_aw(NREGS)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: issue sets, writeback clears (set wins), plus read/issue lookups.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = regfile_pkg::NREGS,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NWR-1:0]                whit,
  input  logic [NWR*calc_aw(NREGS)-1:0] waddr,
  input  logic [NRD*calc_aw(NREGS)-1:0] raddr,
  input  logic                          issue_valid,
  input  logic [calc_aw(NREGS)-1:0]     issue_rd,
  output logic [NRD-1:0]                rbusy,
  output logic                          issue_ready
);

  localparam int AW = calc_aw(NREGS);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] busy_next;
  logic             issue_hit;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int k = 0; k < NWR; k++) begin
      if (whit[k]) clr_vec[waddr[k*AW +: AW]] = 1'b1;
    end
    if (issue_valid && (issue_rd != AW'(REG_ZERO))) set_vec[issue_rd] = 1'b1;
    // A new producer issued in the writeback cycle keeps ownership of the register.
    busy_next = (busy & ~clr_vec) | set_vec;
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  always_comb begin
    issue_hit = 1'b0;
    for (int k = 0; k < NWR; k++) begin
      if (whit[k] && (waddr[k*AW +: AW] == issue_rd)) issue_hit = 1'b1;
    end
    issue_ready = ~busy[issue_rd] | (issue_rd == AW'(REG_ZERO)) | ((BYPASS != 0) & issue_hit);
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rbusy
    logic [AW-1:0] a;
    logic          hit;
    assign a = raddr[j*AW +: AW];
    always_comb begin
      hit = 1'b0;
      for (int k = 0; k < NWR; k++) begin
        if (whit[k] && (waddr[k*AW +: AW] == a)) hit = 1'b1;
      end
    end
    assign rbusy[j] = busy[a] & (a != AW'(REG_ZERO)) & ~((BYPASS != 0) & hit);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and an integrated busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = regfile_pkg::XLEN,
  parameter int NREGS  = regfile_pkg::NREGS,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NWR-1:0]                we,
  input  logic [NWR*calc_aw(NREGS)-1:0] waddr,
  input  logic [NWR*XLEN-1:0]           wdata,
  input  logic [NRD*calc_aw(NREGS)-1:0] raddr,
  output logic [NRD*XLEN-1:0]           rdata,
  output logic [NRD-1:0]                rbusy,
  input  logic                          issue_valid,
  input  logic [calc_aw(NREGS)-1:0]     issue_rd,
  output logic                          issue_ready
);

  localparam int AW = calc_aw(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic [NWR-1:0]  whit;

  // A write counts only off register 0 and outside reset, so reset-cycle writes are lost.
  for (genvar k = 0; k < NWR; k++) begin : g_whit
    assign whit[k] = we[k] & (waddr[k*AW +: AW] != AW'(REG_ZERO)) & ~rst;
  end

  // Later ports overwrite earlier ones, giving the highest index priority on collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (whit[k]) regs[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
      end
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    assign a = raddr[j*AW +: AW];
    always_comb begin
      d = regs[a];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (whit[k] && (waddr[k*AW +: AW] == a)) d = wdata[k*XLEN +: XLEN];
        end
      end
      if (a == AW'(REG_ZERO)) d = '0;
    end
    assign rdata[j*XLEN +: XLEN] = d;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .BYPASS(BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .whit       (whit),
    .waddr      (waddr),
    .raddr      (raddr),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .rbusy      (rbusy),
    .issue_ready(issue_ready)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a 2R/2W bypassing register file alongside a 2R/1W non-bypassing one.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;

  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;

  logic [0:0]  we_b;
  logic [4:0]  waddr_b;
  logic [31:0] wdata_b;
  logic [9:0]  raddr_b;
  logic [63:0] rdata_b;
  logic [1:0]  rbusy_b;
  logic        issue_valid_b;
  logic [4:0]  issue_rd_b;
  logic        issue_ready_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
    .issue_valid(issue_valid_b), .issue_rd(issue_rd_b), .issue_ready(issue_ready_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    we = '0; waddr = '0; wdata = '0; raddr = '0; issue_valid = 1'b0; issue_rd = '0;
    we_b = '0; waddr_b = '0; wdata_b = '0; raddr_b = '0; issue_valid_b = 1'b0; issue_rd_b = '0;
    #2;
    chk("reset_rdata", rdata, 64'h0);
    chk("reset_rbusy", {62'h0, rbusy}, 64'h0);
    chk("reset_ready", {63'h0, issue_ready}, 64'h1);
    tick();
    rst = 1'b0;

    // Test 1: writes to register 0 are discarded, including through bypass.
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hDEADBEEF}; raddr = {5'd0, 5'd0};
    #1;
    chk("r0_bypass_rdata", rdata, 64'h0);
    chk("r0_bypass_rbusy", {62'h0, rbusy}, 64'h0);
    chk("r0_ready", {63'h0, issue_ready}, 64'h1);
    tick();
    we = '0;
    #1;
    chk("r0_after_write", rdata, 64'h0);

    // Test 2: fill registers 1..31 in both instances.
    for (int i = 1; i < 32; i++) begin
      we = 2'b01; waddr = {5'd0, 5'(i)}; wdata = {32'h0, 32'(i * 10)};
      we_b = 1'b1; waddr_b = 5'(i); wdata_b = 32'(i * 10);
      tick();
    end
    we = '0; we_b = '0;
    for (int i = 1; i < 32; i++) begin
      raddr = {5'd0, 5'(i)};
      #1;
      chk($sformatf("rd_p0_%0d", i), rdata, {32'h0, 32'(i * 10)});
      raddr = {5'(i), 5'd0};
      #1;
      chk($sformatf("rd_p1_%0d", i), rdata, {32'(i * 10), 32'h0});
    end
    raddr = {5'd20, 5'd10};
    raddr_b = {5'd20, 5'd10};
    #1;
    chk("rd_10_20", rdata, {32'd200, 32'd100});
    chk("rd_10_20_nb", rdata_b, {32'd200, 32'd100});

    // Test 3: bypass vs. no bypass on the same-cycle write/read of register 5.
    tick();
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'h1234}; raddr = {5'd0, 5'd5};
    we_b = 1'b1; waddr_b = 5'd5; wdata_b = 32'h1234; raddr_b = {5'd0, 5'd5};
    #1;
    chk("bypass_same_cycle", rdata, {32'h0, 32'h1234});
    chk("nobypass_same_cycle", rdata_b, {32'h0, 32'd50});
    tick();
    we = '0; we_b = '0;
    #1;
    chk("nobypass_next_cycle", rdata_b, {32'h0, 32'h1234});

    // Test 4: both write ports hit register 7; port 1 wins.
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h5555, 32'hAAAA}; raddr = {5'd0, 5'd7};
    #1;
    chk("collision_bypass", rdata, {32'h0, 32'h5555});
    tick();
    we = '0;
    #1;
    chk("collision_stored", rdata, {32'h0, 32'h5555});

    // Test 5: scoreboard set, clear, and set-wins-over-clear.
    issue_valid = 1'b1; issue_rd = 5'd3; raddr = {5'd0, 5'd3};
    #1;
    chk("sb_ready_before", {63'h0, issue_ready}, 64'h1);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("sb_rbusy_set", {62'h0, rbusy}, 64'h1);
    chk("sb_ready_set", {63'h0, issue_ready}, 64'h0);
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h33};
    #1;
    chk("sb_rbusy_wb_bypass", {62'h0, rbusy}, 64'h0);
    chk("sb_ready_wb_bypass", {63'h0, issue_ready}, 64'h1);
    tick();
    we = '0;
    #1;
    chk("sb_rbusy_cleared", {62'h0, rbusy}, 64'h0);
    chk("sb_ready_cleared", {63'h0, issue_ready}, 64'h1);
    chk("sb_wb_data", rdata, {32'h0, 32'h33});
    issue_valid = 1'b1; we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h44};
    tick();
    issue_valid = 1'b0; we = '0;
    #1;
    chk("sb_set_wins_rbusy", {62'h0, rbusy}, 64'h1);
    chk("sb_set_wins_ready", {63'h0, issue_ready}, 64'h0);
    chk("sb_set_wins_data", rdata, {32'h0, 32'h44});
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0; raddr = {5'd0, 5'd0};
    #1;
    chk("sb_r0_never_busy", {62'h0, rbusy}, 64'h0);
    chk("sb_r0_ready", {63'h0, issue_ready}, 64'h1);

    // Test 6: asynchronous reset mid-cycle with registers 4 and 9 busy.
    issue_valid = 1'b1; issue_rd = 5'd4;
    tick();
    issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0; issue_rd = 5'd4; raddr = {5'd9, 5'd4};
    #1;
    chk("busy_4_9", {62'h0, rbusy}, 64'h3);
    chk("ready_4_busy", {63'h0, issue_ready}, 64'h0);
    chk("data_4_9", rdata, {32'd90, 32'd40});
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rdata", rdata, 64'h0);
    chk("async_rst_rbusy", {62'h0, rbusy}, 64'h0);
    chk("async_rst_ready", {63'h0, issue_ready}, 64'h1);
    raddr_b = {5'd20, 5'd10};
    #1;
    chk("async_rst_rdata_nb", rdata_b, 64'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_rdata", rdata, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with an integrated busy-bit scoreboard. It is the next generation of the core's 2-read/1-write register file: configurable width, depth, read-port count and write-port count, same-cycle write-to-read bypass, and per-register pending-write tracking for the issue stage. It sits between decode/issue and the writeback stage of the pipeline.

## Interface
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, ≥2); register 0 is hardwired to zero.
- NRD, 2, number of read ports (1–4).
- NWR, 1, number of write ports (1–2).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only.
- AW, log2(NREGS), derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  NWR  per-port write enable.
- waddr  in  NWR*AW  per-port write address; port k uses bits [k*AW +: AW].
- wdata  in  NWR*XLEN  per-port write data.
- raddr  in  NRD*AW  per-port read address.
- rdata  out  NRD*XLEN  per-port read data, combinational.
- rbusy  out  NRD  per-port: the addressed register has a pending write.
- issue_valid  in  1  request to mark issue_rd as pending.
- issue_rd  in  AW  destination register of the issuing instruction.
- issue_ready  out  1  issue_rd has no outstanding pending write (no WAW hazard).

## Operation
- Reset (async, while rst=1): all registers 0, all busy bits 0. Outputs: rdata=0, rbusy=0, issue_ready=1.
- Register 0:
  - Writes to register 0 are discarded.
  - Register 0 never becomes busy.
  - Reads of register 0 return 0 with rbusy=0, including under bypass.
- Write: on a rising edge with we[k]=1 and waddr≠0, the register takes wdata[k] and its busy bit clears.
- Write collision (NWR=2, both ports enabled, same address): the port with the higher index wins the data; busy still clears.
- Read: rdata[j] = reg[raddr[j]].
  - BYPASS=1 and a port is writing raddr[j] this cycle: rdata[j] takes that port's wdata (highest-index port if both) and rbusy[j]=0.
- Scoreboard:
  - issue_valid=1 with issue_rd≠0 sets busy[issue_rd] at the edge.
  - Issue and writeback to the same register in the same cycle: set wins (the new producer owns the register); the data is still written.
  - issue_ready = ~busy[issue_rd] | (issue_rd==0) | (BYPASS & a write to issue_rd this cycle).
  - issue_valid is accepted regardless of issue_ready; gating is the issue stage's job.

## Timing
- Write latency 1 cycle: data is readable from the next cycle, or the same cycle combinationally when BYPASS=1.
- Busy set/clear take effect at the rising edge and are visible the cycle after.
- rdata, rbusy and issue_ready are purely combinational from current state and inputs; no registered outputs.
- rst asserted mid-operation clears state immediately; writes and issues in that cycle are lost.
- rst deassertion is synchronised externally.

## Structure
- Package regfile_pkg holds:
  - localparam defaults XLEN, NREGS;
  - the function computing AW;
  - the REG_ZERO constant;
  - the reg_idx_t typedef.
- Sub-module regfile_scoreboard holds the NREGS busy bits, the set/clear priority and the issue_ready/rbusy lookup.
- Storage and bypass muxes live in regfile_mp.

## Test plan
1. Reset then write reg 0 ← 0xDEADBEEF → every read port returns 0, rbusy=0, issue_ready=1 for rd=0.
2. Write reg i ← i*10 for i=1..31, then read each i on every port paired with reg 0 → i*10 and 0; read ports 10/20 together → 100/200.
3. BYPASS=1: same cycle write reg 5 ← 0x1234 and read reg 5 → rdata=0x1234 that cycle. BYPASS=0: old value that cycle, 0x1234 the next.
4. NWR=2: both ports write reg 7 (0xAAAA on port 0, 0x5555 on port 1) → reg 7 reads 0x5555.
5. Scoreboard:
   - Issue rd=3 → next cycle rbusy=1 on a port reading 3, issue_ready=0 for rd=3.
   - Writeback to 3 → cleared the next cycle.
   - Issue rd=3 in the same cycle as writeback to 3 → still busy.
6. Set busy on regs 4 and 9, assert rst mid-cycle without a clock edge → immediately all rdata=0, rbusy=0, issue_ready=1.
